// File: rtl/usb_bus_timer_pkg.sv
// Shared types and USB timing constants for the SIE bus-turnaround timer.
package usb_timer_pkg;

  // Runtime-selectable timer modes, encoded to match mode_i.
  typedef enum logic [1:0] {
    TIMER_FS     = 2'd0,
    TIMER_HS     = 2'd1,
    TIMER_GAP    = 2'd2,
    TIMER_CUSTOM = 2'd3
  } timer_mode_e;

  // Controller states; EXPIRED and STOPPED are idle states that remember why the run ended.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2,
    ST_STOPPED = 2'd3
  } timer_state_e;

  // Default limits in bit times.
  localparam int FS_TIMEOUT_BITS_DEF = 17;
  localparam int HS_TIMEOUT_BITS_DEF = 776;
  localparam int GAP_BITS_DEF        = 2;

  // Legal USB response-timeout windows in bit times.
  localparam int FS_TIMEOUT_MIN = 16;
  localparam int FS_TIMEOUT_MAX = 18;
  localparam int HS_TIMEOUT_MIN = 736;
  localparam int HS_TIMEOUT_MAX = 816;

endpackage

// File: rtl/usb_bus_timer_if.sv
// Control/status bundle between the SIE (master) and the bus timer (slave).
interface usb_bus_timer_if #(
  parameter int CNT_WID = 10
);
  import usb_timer_pkg::*;

  logic                start_i;
  timer_mode_e         mode_i;
  logic [CNT_WID-1:0]  customLimit_i;
  logic                cancel_i;
  logic                rxGotSignal_i;
  logic                busy_o;
  logic                timeout_o;
  logic                timedOut_o;
  logic                gotSignal_o;
  logic [CNT_WID-1:0]  bitCnt_o;

  modport master (
    output start_i, mode_i, customLimit_i, cancel_i, rxGotSignal_i,
    input  busy_o, timeout_o, timedOut_o, gotSignal_o, bitCnt_o
  );

  modport slave (
    input  start_i, mode_i, customLimit_i, cancel_i, rxGotSignal_i,
    output busy_o, timeout_o, timedOut_o, gotSignal_o, bitCnt_o
  );

endinterface

// File: rtl/usb_bus_timer_bit_tick.sv
// Bit-time prescaler: counts clk48_i cycles and pulses tick on the last cycle of each bit.
module usb_bit_tick #(
  parameter int CLK_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_PER_BIT - 1);

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;

  // Next prescaler value: clear wins, otherwise wrap after the last cycle of a bit.
  always_comb begin
    pre_d = pre_q;
    tick  = en && (pre_q == LAST);
    if (clr) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/usb_bus_timer.sv
// Bus-turnaround timer for the SIE, armed at the end of EOP and counting whole bit times.
module usb_bus_timer
  import usb_timer_pkg::*;
#(
  parameter int CLK_PER_BIT     = 4,
  parameter int FS_TIMEOUT_BITS = FS_TIMEOUT_BITS_DEF,
  parameter int HS_TIMEOUT_BITS = HS_TIMEOUT_BITS_DEF,
  parameter int GAP_BITS        = GAP_BITS_DEF,
  parameter int CNT_WID         = 10
) (
  input logic              clk48_i,
  input logic              rst_n_i,
  usb_bus_timer_if.slave   bus
);

  localparam int CNT_MAX = (1 << CNT_WID) - 1;

  // Parameter sanity checks at elaboration.
  if (CLK_PER_BIT < 2) begin : g_chk_clk
    $error("CLK_PER_BIT must be at least 2");
  end
  if (FS_TIMEOUT_BITS < FS_TIMEOUT_MIN || FS_TIMEOUT_BITS > FS_TIMEOUT_MAX) begin : g_chk_fs
    $error("FS_TIMEOUT_BITS outside the legal USB window");
  end
  if (HS_TIMEOUT_BITS < HS_TIMEOUT_MIN || HS_TIMEOUT_BITS > HS_TIMEOUT_MAX) begin : g_chk_hs
    $error("HS_TIMEOUT_BITS outside the legal USB window");
  end
  if (HS_TIMEOUT_BITS > CNT_MAX || FS_TIMEOUT_BITS > CNT_MAX || GAP_BITS > CNT_MAX
      || GAP_BITS < 1) begin : g_chk_wid
    $error("CNT_WID too narrow for the configured limits");
  end

  timer_state_e        state_q, state_d;
  timer_mode_e         mode_q, mode_d;
  logic [CNT_WID-1:0]  limit_q, limit_d;
  logic [CNT_WID-1:0]  cnt_q, cnt_d;
  logic [CNT_WID-1:0]  cnt_inc;
  logic                fire_q, fire_d;
  logic                timeout_q, timeout_d;
  logic                timed_out_q, timed_out_d;
  logic                got_q, got_d;
  logic                busy_q, busy_d;
  logic                tick;
  logic                pre_en;
  logic                pre_clr;

  assign pre_en  = (state_q == ST_RUN);
  assign pre_clr = bus.start_i || bus.cancel_i || (state_q != ST_RUN);
  assign cnt_inc = cnt_q + 1'b1;

  usb_bit_tick #(
    .CLK_PER_BIT(CLK_PER_BIT)
  ) u_bit_tick (
    .clk   (clk48_i),
    .rst_n (rst_n_i),
    .en    (pre_en),
    .clr   (pre_clr),
    .tick  (tick)
  );

  // Next-state and flag logic; cancel beats start beats signal beats tick.
  // The expiry pulse is issued one cycle after entering EXPIRED via fire_q.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    limit_d     = limit_q;
    cnt_d       = cnt_q;
    fire_d      = 1'b0;
    timeout_d   = 1'b0;
    timed_out_d = timed_out_q;
    got_d       = got_q;

    if (bus.cancel_i) begin
      state_d = ST_IDLE;
      if (bus.start_i) begin
        timed_out_d = 1'b0;
        got_d       = 1'b0;
      end
    end else if (bus.start_i) begin
      mode_d = bus.mode_i;
      unique case (bus.mode_i)
        TIMER_FS:  limit_d = CNT_WID'(FS_TIMEOUT_BITS);
        TIMER_HS:  limit_d = CNT_WID'(HS_TIMEOUT_BITS);
        TIMER_GAP: limit_d = CNT_WID'(GAP_BITS);
        default:   limit_d = (bus.customLimit_i == '0) ? CNT_WID'(1) : bus.customLimit_i;
      endcase
      cnt_d       = '0;
      timed_out_d = 1'b0;
      got_d       = 1'b0;
      state_d     = ST_RUN;
    end else begin
      if (fire_q) begin
        timeout_d   = 1'b1;
        timed_out_d = 1'b1;
      end
      if (state_q == ST_RUN) begin
        if (bus.rxGotSignal_i && (mode_q != TIMER_GAP)) begin
          state_d = ST_STOPPED;
          got_d   = 1'b1;
        end else if (tick) begin
          cnt_d = cnt_inc;
          if (cnt_inc == limit_q) begin
            state_d = ST_EXPIRED;
            fire_d  = 1'b1;
          end
        end
      end
    end
  end

  // Registered busy follows the next state so it is glitch-free.
  always_comb begin
    busy_d = (state_d == ST_RUN);
  end

  // State, counters and flags.
  always_ff @(posedge clk48_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      mode_q      <= TIMER_FS;
      limit_q     <= '0;
      cnt_q       <= '0;
      fire_q      <= 1'b0;
      timeout_q   <= 1'b0;
      timed_out_q <= 1'b0;
      got_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      limit_q     <= limit_d;
      cnt_q       <= cnt_d;
      fire_q      <= fire_d;
      timeout_q   <= timeout_d;
      timed_out_q <= timed_out_d;
      got_q       <= got_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.busy_o      = busy_q;
  assign bus.timeout_o   = timeout_q;
  assign bus.timedOut_o  = timed_out_q;
  assign bus.gotSignal_o = got_q;
  assign bus.bitCnt_o    = cnt_q;

endmodule

// File: doc/usb_bus_timer.md
Name: usb_bus_timer

Overview:
Parametrised bus-turnaround timer for the SIE, clocked only from clk48_i, with an internal bit-time prescaler, so the receive clock domain is not needed.
Supports four runtime-selectable modes:
- full-speed response timeout
- high-speed response timeout
- transmit inter-packet gap
- custom limit
Armed by the SIE at the SE0-to-J transition at the end of EOP. Reports expiry as a one-cycle pulse plus a sticky flag, and exposes the elapsed bit count.

Parameters:
CLK_PER_BIT, 4, clk48_i cycles per bit time (>=2)
FS_TIMEOUT_BITS, 17, FS response timeout (must lie in 16..18 bit times)
HS_TIMEOUT_BITS, 776, HS response timeout (must lie in 736..816 bit times)
GAP_BITS, 2, minimum bit times before the device may transmit
CNT_WID, 10, bit counter width; must hold max(FS_TIMEOUT_BITS, HS_TIMEOUT_BITS, GAP_BITS, 2**CNT_WID-1)

Ports:
clk48_i  in  1  48 MHz clock, sole clock
rst_n_i  in  1  asynchronous, active-low reset
start_i  in  1  arm/re-arm pulse; samples mode_i and customLimit_i
mode_i  in  2  0=FS, 1=HS, 2=GAP, 3=CUSTOM
customLimit_i  in  CNT_WID  limit in bit times for CUSTOM
cancel_i  in  1  abort a running timer without flagging a timeout
rxGotSignal_i  in  1  receiver saw non-idle signalling (level or pulse)
busy_o  out  1  timer running
timeout_o  out  1  one-cycle pulse on expiry
timedOut_o  out  1  sticky expiry flag; cleared by start_i or reset
gotSignal_o  out  1  sticky: run ended by rxGotSignal_i; cleared by start_i or reset
bitCnt_o  out  CNT_WID  elapsed whole bit times of the current/last run

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; prescaler 0.
- States: IDLE, RUN, EXPIRED, STOPPED. EXPIRED and STOPPED behave as IDLE except for the held flags and count.
- Priority per cycle, highest first: reset, cancel_i, start_i, rxGotSignal_i, tick/expiry.
- start_i accepted in any state:
  - Latches limit: FS/HS/GAP use the parameter value; CUSTOM uses customLimit_i, with 0 coerced to 1.
  - Latches mode.
  - Clears bitCnt_o, prescaler, timedOut_o and gotSignal_o; next state RUN.
  - A start_i during RUN restarts the run from zero.
- Tick and count:
  - In RUN the prescaler counts 0..CLK_PER_BIT-1.
  - A tick fires in the cycle where prescaler==CLK_PER_BIT-1; bitCnt_o increments on that tick.
- Expiry: the tick that makes bitCnt_o equal the limit moves to EXPIRED.
  - timeout_o is high for exactly one cycle, in the cycle after the last tick edge.
  - Latency: timeout_o is first high limit*CLK_PER_BIT+1 rising edges after the edge that sampled start_i.
  - timedOut_o rises in the same cycle as timeout_o.
- Signal: rxGotSignal_i high in RUN with mode != GAP gives STOPPED on the next edge.
  - gotSignal_o=1, bitCnt_o frozen, no timeout.
  - In GAP mode rxGotSignal_i is ignored.
- Simultaneous rxGotSignal_i and final tick: the signal wins (STOPPED, no timeout). A signal arriving before the limit is legal.
- cancel_i: from any state to IDLE, busy_o=0. Flags and bitCnt_o are held, except cancel_i with start_i in the same cycle, which leaves flags cleared.
- busy_o = (state==RUN), registered.
- Counter never wraps: the limit is at most 2**CNT_WID-1 by parameter constraint.
- Inputs are synchronous to clk48_i; any cross-domain synchronisation of rxGotSignal_i happens upstream.

Decomposition:
- Package usb_timer_pkg:
  - mode enum (TIMER_FS, TIMER_HS, TIMER_GAP, TIMER_CUSTOM)
  - state enum
  - default FS/HS/GAP bit constants
  - USB timing bounds (16, 18, 736, 816) for elaboration-time assertions on the parameters
- Sub-module usb_bit_tick: prescaler with clear input and tick output, parametrised by CLK_PER_BIT.

Test Plan:
- FS, CLK_PER_BIT=4, start_i at edge 0, no signal -> timeout_o high only in cycle 69; timedOut_o=1 after it; bitCnt_o=17; busy_o=0.
- FS, rxGotSignal_i pulse at cycle 41 -> STOPPED, gotSignal_o=1, bitCnt_o=10, timeout_o never asserts.
- HS, no signal -> timeout_o at cycle 3105. GAP with rxGotSignal_i held high -> signal ignored, timeout_o at cycle 9.
- Edge cases:
  - CUSTOM with customLimit_i=0 -> timeout_o at cycle 5.
  - rxGotSignal_i coincident with the final tick -> no timeout, gotSignal_o=1.
- Restart and abort:
  - start_i again at cycle 30 of an FS run -> expiry moves to cycle 99.
  - cancel_i at cycle 20 -> busy_o=0, no timeout.
  - rst_n_i pulsed low mid-run -> all outputs 0 immediately; timer stays IDLE after release.
